// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter sharing one UART TX byte
//            stream; UART_ARB_TAG_EN adds an ASCII owner tag per grant.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input wire               clk,
  input wire               rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BW-1:0]      C_MAX_BURST    = BW'(MAX_BURST);
  localparam logic [TW-1:0]      C_IDLE_TIMEOUT = TW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]      C_LAST_IDX     = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] C_ONE          = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOCK = 2'd1;
`ifdef UART_ARB_TAG_EN
  localparam logic [1:0] S_TAG  = 2'd2;
`endif

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_ptr_q, last_ptr_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]      idle_cnt_q, idle_cnt_d;

  logic               w_pick_found;
  logic [IW-1:0]      w_pick_idx;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic               w_release;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic [NUM_REQ-1:0] w_req_ready;

  // last_ptr doubles as the owner index while a grant is held
  assign w_own_valid = bus.req_valid[last_ptr_q];
  assign w_own_last  = bus.req_last[last_ptr_q];
  assign w_own_data  = bus.req_data[8*last_ptr_q +: 8];

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_pick_found && bus.req_valid[(int'(last_ptr_q) + k) % NUM_REQ]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IW'((int'(last_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_ptr_q  <= C_LAST_IDX;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    w_release   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_pick_found) begin
          grant_d     = C_ONE << w_pick_idx;
          last_ptr_d  = w_pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
`ifdef UART_ARB_TAG_EN
          state_d     = S_TAG;
`else
          state_d     = S_LOCK;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        if (bus.tx_ready) state_d = S_LOCK;
      end
`endif
      S_LOCK: begin
        // a stalled byte (valid high, tx_ready low) leaves both counters alone
        if (w_own_valid && bus.tx_ready) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          w_release   = w_own_last || (burst_cnt_d == C_MAX_BURST);
        end else if (!w_own_valid) begin
          idle_cnt_d  = idle_cnt_q + 1'b1;
          w_release   = (idle_cnt_d == C_IDLE_TIMEOUT);
        end
        if (w_release) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        burst_cnt_d = '0;
        idle_cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    w_tx_valid  = 1'b0;
    w_tx_data   = '0;
    w_req_ready = '0;
    case (state_q)
      S_LOCK: begin
        w_tx_valid  = w_own_valid;
        w_tx_data   = w_own_data;
        w_req_ready = grant_q & {NUM_REQ{bus.tx_ready}};
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        w_tx_valid  = 1'b1;
        w_tx_data   = 8'h30 + 8'(last_ptr_q);
      end
`endif
      default: ;
    endcase
  end

  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = w_tx_data;
  assign bus.req_ready = w_req_ready;
  assign bus.grant     = grant_q;
  assign bus.busy      = |grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Randomized and scenario-driven bench for uart_tx_arbiter, compared cycle by
// cycle against a queue-based model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 64;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .MAX_BURST   (MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // per-requester pending bytes: bit 8 = last flag
  logic [8:0]         src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] en;
  logic               tx_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_bytes = 0;
  int mdl_bytes = 0;

  // reference model: owner index (-1 when idle), priority pointer, counters
  int m_owner, m_ptr, m_burst, m_idle;
  bit m_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [7:0] base, input bit with_last);
    for (int b = 0; b < len; b++)
      src_q[r].push_back({with_last && (b == len - 1), 8'(int'(base) + b)});
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = NUM_REQ - 1;
    m_burst = 0;
    m_idle  = 0;
    m_tag   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_txv"},   32'(bus.tx_valid), 32'd0);
    check({tag, "_txd"},   32'(bus.tx_data), 32'd0);
    check({tag, "_rdy"},   32'(bus.req_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = '0;
    tx_rdy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    bus.req_data  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
    model_reset();
    #2;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // one clock: drive, compare against the model, advance the model
  task automatic step();
    logic [NUM_REQ-1:0] v, l, e_grant, e_ready;
    logic [7:0]         d [NUM_REQ];
    logic [8:0]         h;
    logic               e_valid;
    logic [7:0]         e_data;
    int                 o;
    bit                 found;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        h    = src_q[i][0];
        d[i] = h[7:0];
        l[i] = h[8];
        v[i] = en[i];
      end else begin
        d[i] = 8'h00;
        l[i] = 1'b0;
        v[i] = 1'b0;
      end
      bus.req_data[8*i +: 8] = d[i];
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.tx_ready  = tx_rdy;
    #1;
    o       = m_owner;
    e_grant = '0;
    e_ready = '0;
    e_valid = 1'b0;
    e_data  = 8'h00;
    if (o >= 0) begin
      e_grant[o] = 1'b1;
      if (m_tag) begin
        e_valid = 1'b1;
        e_data  = 8'h30 + 8'(o);
      end else begin
        e_valid    = v[o];
        e_data     = d[o];
        e_ready[o] = tx_rdy;
      end
    end
    check("grant",     32'(bus.grant), 32'(e_grant));
    check("busy",      32'(bus.busy), 32'(o >= 0));
    check("tx_valid",  32'(bus.tx_valid), 32'(e_valid));
    check("tx_data",   32'(bus.tx_data), 32'(e_data));
    check("req_ready", 32'(bus.req_ready), 32'(e_ready));
    if (bus.tx_valid && bus.tx_ready && (bus.req_ready != '0)) dut_bytes++;

    if (o < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && v[(m_ptr + k) % NUM_REQ]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % NUM_REQ;
          m_ptr   = m_owner;
          m_tag   = TAG_EN;
          m_burst = 0;
          m_idle  = 0;
        end
      end
    end else if (m_tag) begin
      if (tx_rdy) m_tag = 1'b0;
    end else if (v[o] && tx_rdy) begin
      void'(src_q[o].pop_front());
      mdl_bytes++;
      m_burst++;
      m_idle = 0;
      if (l[o] || m_burst == MAX_BURST) m_owner = -1;
    end else if (!v[o]) begin
      m_idle++;
      if (m_idle == IDLE_TIMEOUT) m_owner = -1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    do_reset();
    en = '1;

    // single 3-byte packet from requester 0
    push_pkt(0, 3, 8'h41, 1'b1);
    run(6);

    // all requesters with 1-byte packets: round-robin order
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 1, 8'h50 + 8'(16*r + i), 1'b1);
    run(24);

    // burst limit: 20 bytes without last from 2, requester 3 waiting
    push_pkt(2, 20, 8'h80, 1'b0);
    run(2);
    push_pkt(3, 2, 8'hC0, 1'b1);
    run(110);

    // idle timeout with requester 0 pending
    push_pkt(1, 1, 8'h11, 1'b0);
    run(3);
    push_pkt(0, 2, 8'h21, 1'b1);
    run(80);

    // tx_ready stall mid-packet
    push_pkt(0, 6, 8'h61, 1'b1);
    run(3);
    tx_rdy = 1'b0;
    run(10);
    tx_rdy = 1'b1;
    run(8);

    // reset mid-packet; priority restarts at requester 0
    push_pkt(1, 10, 8'hA0, 1'b1);
    run(4);
    do_reset();
    en = '1;
    push_pkt(1, 1, 8'hB1, 1'b1);
    push_pkt(0, 1, 8'hB0, 1'b1);
    run(8);

    // tag scenario (plain byte stream when the tag feature is absent)
    push_pkt(2, 1, 8'h58, 1'b1);
    run(6);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        int r;
        r = int'($urandom_range(0, NUM_REQ - 1));
        if (src_q[r].size() < 40)
          push_pkt(r, int'($urandom_range(1, 20)), 8'($urandom), $urandom_range(0, 9) < 7);
      end
      for (int i = 0; i < NUM_REQ; i++) en[i] = ($urandom_range(0, 99) < 85);
      tx_rdy = ($urandom_range(0, 4) != 0);
      step();
    end
    en     = '1;
    tx_rdy = 1'b1;
    run(300);

    check("byte_count", 32'(dut_bytes), 32'(mdl_bytes));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
